addr_ch_pos_walker: RTL

ADDR_CH_POS_WALKER -- requirements
Module: addr_ch_pos_walker

---
 rtl/addr_ch_pos_walker_if.sv | 23 ++
 rtl/addr_ch_pos_walker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/addr_ch_pos_walker_if.sv
// rtl/addr_ch_pos_walker_if.sv - address handshake bundle between walker and downstream consumer
interface addr_ch_pos_walker_if;
  logic        addr_valid_o;
  logic        addr_ready_i;
  logic [15:0] addr_row_o;
  logic [13:0] addr_col_o;

  // walker side drives the address and valid, samples ready
  modport master (
    output addr_valid_o,
    output addr_row_o,
    output addr_col_o,
    input  addr_ready_i
  );

  // consumer side samples the address, drives ready
  modport slave (
    input  addr_valid_o,
    input  addr_row_o,
    input  addr_col_o,
    output addr_ready_i
  );
endinterface

// File: rtl/addr_ch_pos_walker.sv
// rtl/addr_ch_pos_walker.sv - strided row/column position walker for one channel cluster
module addr_ch_pos_walker (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  cfg_row_column_i,
  input  logic [2:0]            cfg_ch_cluster_num_i,
  input  logic [15:0]           cfg_row_num_1st_i,
  input  logic [13:0]           cfg_column_num_1st_i,
  input  logic [15:0]           cfg_start_pos_row_i,
  input  logic [13:0]           cfg_start_pos_col_i,
  addr_ch_pos_walker_if.master  addr_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           addr_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [3:0]  r_stride;
  logic        r_row_major;
  logic [15:0] r_rmax;
  logic [13:0] r_cmax;
  logic [15:0] r_row;
  logic [13:0] r_col;
  logic [3:0]  r_step_cnt;
  logic [15:0] r_cnt;
  logic        r_done;

  logic        w_valid;
  logic        w_busy;
  logic        w_start_bad;
  logic        w_at_end;
  logic [15:0] w_step_row;
  logic [13:0] w_step_col;

  // A start position outside the array ends the walk without presenting anything
  assign w_start_bad = (cfg_start_pos_row_i > cfg_row_num_1st_i) ||
                       (cfg_start_pos_col_i > cfg_column_num_1st_i);

  // The last cell is the same in both scan orders
  assign w_at_end = (r_row == r_rmax) && (r_col == r_cmax);

  // Single-position advance with wrap on the fast axis
  always_comb begin
    w_step_row = r_row;
    w_step_col = r_col;
    if (r_row_major) begin
      if (r_col == r_cmax) begin
        w_step_col = 14'd0;
        w_step_row = r_row + 16'd1;
      end else begin
        w_step_col = r_col + 14'd1;
      end
    end else begin
      if (r_row == r_rmax) begin
        w_step_row = 16'd0;
        w_step_col = r_col + 14'd1;
      end else begin
        w_step_row = r_row + 16'd1;
      end
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start_i) begin
          w_next_state = w_start_bad ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        w_valid = 1'b1;
        if (addr_if.addr_ready_i) begin
          w_next_state = ST_STEP;
        end
      end
      ST_STEP: begin
        if (w_at_end) begin
          w_next_state = ST_DONE;
        end else if (r_step_cnt == 4'd1) begin
          w_next_state = ST_RUN;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register; reset overrides any start seen in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Configuration latch, position, step counter and accepted-address count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stride    <= 4'd0;
      r_row_major <= 1'b0;
      r_rmax      <= 16'd0;
      r_cmax      <= 14'd0;
      r_row       <= 16'd0;
      r_col       <= 14'd0;
      r_step_cnt  <= 4'd0;
      r_cnt       <= 16'd0;
      r_done      <= 1'b0;
    end else begin
      // done is registered off the DONE state, so it pulses as the walker re-enters IDLE
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_stride    <= {1'b0, cfg_ch_cluster_num_i} + 4'd1;
            r_row_major <= cfg_row_column_i;
            r_rmax      <= cfg_row_num_1st_i;
            r_cmax      <= cfg_column_num_1st_i;
            r_row       <= cfg_start_pos_row_i;
            r_col       <= cfg_start_pos_col_i;
            r_cnt       <= 16'd0;
          end
        end
        ST_RUN: begin
          if (addr_if.addr_ready_i) begin
            r_step_cnt <= r_stride;
            if (r_cnt != 16'hFFFF) begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        ST_STEP: begin
          if (!w_at_end) begin
            r_row      <= w_step_row;
            r_col      <= w_step_col;
            r_step_cnt <= r_step_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign addr_if.addr_valid_o = w_valid;
  assign addr_if.addr_row_o   = r_row;
  assign addr_if.addr_col_o   = r_col;
  assign busy_o               = w_busy;
  assign done_o               = r_done;
  assign addr_cnt_o           = r_cnt;

endmodule
